// File: rtl/alu_mem_pkg.sv
// ---------------------------------------------------------------------------
// alu_mem_pkg
// Shared constants for the LEGv8 execute/memory stage:
//   - alu_op_e   : 4-bit ALU operation codes driven on Operation
//   - OPC_*      : 11-bit R-type opcodes (instruction[31:21])
//   - ALUOP_*    : main-control ALUOP encodings
// ---------------------------------------------------------------------------
package alu_mem_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [3:0] {
        OP_AND     = 4'b0000,
        OP_ORR     = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SUB     = 4'b0110,
        OP_PASSB   = 4'b0111,
        OP_NOR     = 4'b1100,
        OP_INVALID = 4'b1111
    } alu_op_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // ALUOP[1] set means R-type regardless of ALUOP[0].
    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage : alu_mem_pkg

// File: rtl/alu_mem_stage_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// 64-bit combinational ALU with Zero flag.
// Optional feature macro: ALU_FLAGS_EN (adds Negative/Carry/Overflow).
// Ports:
//   a_i, b_i    : operands (A = Rn, B = Rm or immediate)
//   op_i        : 4-bit operation code (alu_op_e values)
//   y_o         : result, modulo 2^64
//   zero_o      : 1 when y_o == 0
//   neg_o, carry_o, ovf_o : only with ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module alu_core
    import alu_mem_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
`ifdef ALU_FLAGS_EN
    output logic              neg_o,
    output logic              carry_o,
    output logic              ovf_o,
`endif
    output logic [DATA_W-1:0] y_o,
    output logic              zero_o
);

    // One extra bit captures carry-out; SUB is a + ~b + 1 so its carry
    // is the ARM-style NOT-borrow.
    logic [DATA_W:0] sum_add;
    logic [DATA_W:0] sum_sub;

    assign sum_add = {1'b0, a_i} + {1'b0, b_i};
    assign sum_sub = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:   y_o = a_i & b_i;
            OP_ORR:   y_o = a_i | b_i;
            OP_ADD:   y_o = sum_add[DATA_W-1:0];
            OP_SUB:   y_o = sum_sub[DATA_W-1:0];
            OP_PASSB: y_o = b_i;
            OP_NOR:   y_o = ~(a_i | b_i);
            default:  y_o = '0;
        endcase
    end

    assign zero_o = ~|y_o;

`ifdef ALU_FLAGS_EN
    assign neg_o = y_o[DATA_W-1];

    always_comb begin
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                carry_o = sum_add[DATA_W];
                ovf_o   = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                          (sum_add[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                carry_o = sum_sub[DATA_W];
                ovf_o   = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                          (sum_sub[DATA_W-1] != a_i[DATA_W-1]);
            end
            default: begin
                carry_o = 1'b0;
                ovf_o   = 1'b0;
            end
        endcase
    end
`endif

endmodule : alu_core

// File: rtl/alu_mem_stage.sv
// ---------------------------------------------------------------------------
// alu_mem_stage
// Execute/memory stage of the single-cycle LEGv8 datapath: ALU operation
// decode, 64-bit ALU (alu_core) and a DEPTH x 64-bit doubleword data memory.
// Optional feature macro: ALU_FLAGS_EN (adds Negative/Carry/Overflow outputs).
// Ports:
//   Clk          : clock, memory writes on rising edge
//   Reset        : asynchronous active-low, clears the memory array
//   ALUOP        : 00 load/store, 01 CBZ, 1x R-type
//   OPCode       : instruction[31:21]
//   R1, R2       : ALU operands A and B
//   WriteData    : store data
//   MemoryRead   : read enable (ReadData is 0 when low)
//   MemoryWrite  : write enable
//   Operation    : decoded ALU mode
//   Out          : ALU result, also the byte address
//   Zero         : Out == 0
//   ReadData     : combinational memory read data
// ---------------------------------------------------------------------------
module alu_mem_stage
    import alu_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        ALUOP,
    input  logic [10:0]       OPCode,
    input  logic [DATA_W-1:0] R1,
    input  logic [DATA_W-1:0] R2,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemoryRead,
    input  logic              MemoryWrite,
`ifdef ALU_FLAGS_EN
    output logic              Negative,
    output logic              Carry,
    output logic              Overflow,
`endif
    output logic [3:0]        Operation,
    output logic [DATA_W-1:0] Out,
    output logic              Zero,
    output logic [DATA_W-1:0] ReadData
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     idx;

    // Operation decode
    always_comb begin
        Operation = OP_INVALID;
        if (ALUOP[1]) begin
            case (OPCode)
                OPC_ADD: Operation = OP_ADD;
                OPC_SUB: Operation = OP_SUB;
                OPC_AND: Operation = OP_AND;
                OPC_ORR: Operation = OP_ORR;
                default: Operation = OP_INVALID;
            endcase
        end else if (ALUOP == ALUOP_CBZ) begin
            Operation = OP_PASSB;
        end else begin
            Operation = OP_ADD;
        end
    end

    alu_core u_alu (
        .a_i     (R1),
        .b_i     (R2),
        .op_i    (Operation),
`ifdef ALU_FLAGS_EN
        .neg_o   (Negative),
        .carry_o (Carry),
        .ovf_o   (Overflow),
`endif
        .y_o     (Out),
        .zero_o  (Zero)
    );

    // Doubleword index: byte offset bits dropped, upper bits wrap.
    assign idx = Out[AW+2:3];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemoryWrite) begin
            mem_q[idx] <= WriteData;
        end
    end

    // Reset gating keeps ReadData at 0 during reset even before the
    // asynchronous clear has propagated through the array.
    assign ReadData = (MemoryRead && Reset) ? mem_q[idx] : '0;

endmodule : alu_mem_stage

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

    localparam int DEPTH = 32;

    logic        Clk;
    logic        Reset;
    logic [1:0]  ALUOP;
    logic [10:0] OPCode;
    logic [63:0] R1, R2, WriteData;
    logic        MemoryRead, MemoryWrite;
    logic [3:0]  Operation;
    logic [63:0] Out;
    logic        Zero;
    logic [63:0] ReadData;
`ifdef ALU_FLAGS_EN
    logic        Negative, Carry, Overflow;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [10:0] C_ADD = 11'b10001011000;
    localparam logic [10:0] C_SUB = 11'b11001011000;
    localparam logic [10:0] C_AND = 11'b10001010000;
    localparam logic [10:0] C_ORR = 11'b10101010000;

    alu_mem_stage #(.DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ALUOP       (ALUOP),
        .OPCode      (OPCode),
        .R1          (R1),
        .R2          (R2),
        .WriteData   (WriteData),
        .MemoryRead  (MemoryRead),
        .MemoryWrite (MemoryWrite),
`ifdef ALU_FLAGS_EN
        .Negative    (Negative),
        .Carry       (Carry),
        .Overflow    (Overflow),
`endif
        .Operation   (Operation),
        .Out         (Out),
        .Zero        (Zero),
        .ReadData    (ReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic test_reset();
        Reset = 1'b0;
        ALUOP = 2'b00; OPCode = '0; R1 = 64'h0; R2 = 64'h0;
        WriteData = 64'h1234; MemoryRead = 1'b1; MemoryWrite = 1'b1;
        #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL reset_read got=%h exp=%h", ReadData, 64'h0);
        end
        @(posedge Clk); #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL reset_write_blocked got=%h exp=%h", ReadData, 64'h0);
        end
        MemoryWrite = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL reset_after_release got=%h exp=%h", ReadData, 64'h0);
        end
        MemoryRead = 1'b0;
    endtask

    task automatic test_rtype();
        ALUOP = 2'b10; OPCode = C_ADD; R1 = 64'd5; R2 = 64'd7; #1;
        checks++;
        if (Operation !== 4'b0010 || Out !== 64'd12 || Zero !== 1'b0) begin
            errors++; $display("FAIL add got op=%b out=%0d z=%b exp op=0010 out=12 z=0", Operation, Out, Zero);
        end
        OPCode = C_SUB; R1 = 64'd7; R2 = 64'd7; #1;
        checks++;
        if (Operation !== 4'b0110 || Out !== 64'd0 || Zero !== 1'b1) begin
            errors++; $display("FAIL sub_zero got op=%b out=%0d z=%b exp op=0110 out=0 z=1", Operation, Out, Zero);
        end
        R1 = 64'd3; R2 = 64'd5; #1;
        checks++;
        if (Out !== 64'hFFFF_FFFF_FFFF_FFFE || Zero !== 1'b0) begin
            errors++; $display("FAIL sub_wrap got out=%h z=%b exp out=fffffffffffffffe z=0", Out, Zero);
        end
        OPCode = C_AND; R1 = 64'hF0F0; R2 = 64'hFF00; #1;
        checks++;
        if (Operation !== 4'b0000 || Out !== 64'hF000) begin
            errors++; $display("FAIL and got op=%b out=%h exp op=0000 out=f000", Operation, Out);
        end
        OPCode = C_ORR; #1;
        checks++;
        if (Operation !== 4'b0001 || Out !== 64'hFFF0) begin
            errors++; $display("FAIL orr got op=%b out=%h exp op=0001 out=fff0", Operation, Out);
        end
        OPCode = 11'b11111111111; #1;
        checks++;
        if (Operation !== 4'b1111 || Out !== 64'h0 || Zero !== 1'b1) begin
            errors++; $display("FAIL invalid got op=%b out=%h z=%b exp op=1111 out=0 z=1", Operation, Out, Zero);
        end
        ALUOP = 2'b11; OPCode = C_ADD; R1 = 64'hFFFF_FFFF_FFFF_FFFF; R2 = 64'd1; #1;
        checks++;
        if (Operation !== 4'b0010 || Out !== 64'h0 || Zero !== 1'b1) begin
            errors++; $display("FAIL aluop11_add_wrap got op=%b out=%h z=%b exp op=0010 out=0 z=1", Operation, Out, Zero);
        end
    endtask

    task automatic test_cbz();
        ALUOP = 2'b01; OPCode = C_SUB; R1 = 64'd99; R2 = 64'd0; #1;
        checks++;
        if (Operation !== 4'b0111 || Out !== 64'd0 || Zero !== 1'b1) begin
            errors++; $display("FAIL cbz_zero got op=%b out=%0d z=%b exp op=0111 out=0 z=1", Operation, Out, Zero);
        end
        R2 = 64'd3; #1;
        checks++;
        if (Out !== 64'd3 || Zero !== 1'b0) begin
            errors++; $display("FAIL cbz_nonzero got out=%0d z=%b exp out=3 z=0", Out, Zero);
        end
    endtask

    task automatic test_store_load();
        @(negedge Clk);
        ALUOP = 2'b00; OPCode = '0; R1 = 64'h10; R2 = 64'h8;
        WriteData = 64'hDEAD_BEEF; MemoryWrite = 1'b1; MemoryRead = 1'b1; #1;
        checks++;
        if (Operation !== 4'b0010 || Out !== 64'h18) begin
            errors++; $display("FAIL ldst_addr got op=%b out=%h exp op=0010 out=18", Operation, Out);
        end
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL read_before_edge got=%h exp=%h", ReadData, 64'h0);
        end
        @(posedge Clk); #1;
        MemoryWrite = 1'b0;
        checks++;
        if (ReadData !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL load got=%h exp=%h", ReadData, 64'hDEAD_BEEF);
        end
        R1 = 64'h18 + DEPTH * 8; R2 = 64'h0; #1;
        checks++;
        if (ReadData !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL load_wrap got=%h exp=%h", ReadData, 64'hDEAD_BEEF);
        end
        R1 = 64'h1B; #1;
        checks++;
        if (ReadData !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL load_lowbits got=%h exp=%h", ReadData, 64'hDEAD_BEEF);
        end
        R1 = 64'h20; #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL load_other_index got=%h exp=%h", ReadData, 64'h0);
        end
        // second store at a different index, back to back with a read
        @(negedge Clk);
        R1 = 64'h0; R2 = 64'h20; WriteData = 64'hCAFE_F00D_0000_0001; MemoryWrite = 1'b1;
        @(posedge Clk); #1;
        MemoryWrite = 1'b0;
        checks++;
        if (ReadData !== 64'hCAFE_F00D_0000_0001) begin
            errors++; $display("FAIL load_second got=%h exp=%h", ReadData, 64'hCAFE_F00D_0000_0001);
        end
        R1 = 64'h18; R2 = 64'h0; #1;
        checks++;
        if (ReadData !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL first_kept got=%h exp=%h", ReadData, 64'hDEAD_BEEF);
        end
    endtask

    task automatic test_read_disable();
        MemoryRead = 1'b0; R1 = 64'h18; R2 = 64'h0; #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL read_disabled got=%h exp=%h", ReadData, 64'h0);
        end
    endtask

    task automatic test_reset_clear();
        MemoryRead = 1'b1; ALUOP = 2'b00; R1 = 64'h18; R2 = 64'h0;
        @(posedge Clk); #2;
        Reset = 1'b0; #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL async_clear got=%h exp=%h", ReadData, 64'h0);
        end
        WriteData = 64'h5555; MemoryWrite = 1'b1;
        @(posedge Clk); #1;
        MemoryWrite = 1'b0;
        @(negedge Clk);
        Reset = 1'b1; #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL cleared_after_release got=%h exp=%h", ReadData, 64'h0);
        end
        R1 = 64'h20; #1;
        checks++;
        if (ReadData !== 64'h0) begin
            errors++; $display("FAIL cleared_second got=%h exp=%h", ReadData, 64'h0);
        end
        // write works again once reset is high
        R1 = 64'h18; WriteData = 64'h7777; MemoryWrite = 1'b1;
        @(posedge Clk); #1;
        MemoryWrite = 1'b0;
        checks++;
        if (ReadData !== 64'h7777) begin
            errors++; $display("FAIL write_after_reset got=%h exp=%h", ReadData, 64'h7777);
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        ALUOP = 2'b10; OPCode = C_ADD; R1 = 64'h7FFF_FFFF_FFFF_FFFF; R2 = 64'd1; #1;
        checks++;
        if (Overflow !== 1'b1 || Negative !== 1'b1 || Carry !== 1'b0) begin
            errors++; $display("FAIL flags_add_ovf got v=%b n=%b c=%b exp v=1 n=1 c=0", Overflow, Negative, Carry);
        end
        OPCode = C_SUB; R1 = 64'd7; R2 = 64'd7; #1;
        checks++;
        if (Overflow !== 1'b0 || Negative !== 1'b0 || Carry !== 1'b1) begin
            errors++; $display("FAIL flags_sub_eq got v=%b n=%b c=%b exp v=0 n=0 c=1", Overflow, Negative, Carry);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_cbz();
        test_store_load();
        test_read_disable();
        test_reset_clear();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_mem_stage
